// File: rtl/bidir_link_pkg.sv
// Shared types and constants for the half-duplex single-wire link controller.
package bidir_link_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StTx,
      StTurnRx,
      StRxWait,
      StRxData,
      StTurnTx
   } state_e;

   localparam logic START_LVL = 1'b1;

   // Width of a counter that has to hold values 0..max_val.
   function automatic int unsigned cnt_w(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/bidir_link_if.sv
// Command/response handshake bundle between a host and the link controller.
interface bidir_link_if #(
   parameter int unsigned DATA_W = 8
);
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              expect_rsp;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_timeout;
   logic              busy;
   logic              io_oe;

   modport master (
      output tx_data, tx_valid, expect_rsp,
      input  tx_ready, rx_data, rx_valid, rx_timeout, busy, io_oe
   );

   modport slave (
      input  tx_data, tx_valid, expect_rsp,
      output tx_ready, rx_data, rx_valid, rx_timeout, busy, io_oe
   );
endinterface

// File: rtl/bidir_pad_cell.sv
// Tristate driver for the shared link line plus the raw input sample path.
module bidir_pad_cell (
   input  logic oe,
   input  logic out,
   output logic in,
   inout  wire  io
);
   assign io = oe ? out : 1'bz;
   assign in = io;
endmodule

// File: rtl/bidir_link_ctrl.sv
// Half-duplex single-wire link controller: sends a start-bit framed command LSB first,
// turns the line around and optionally captures a framed response from the far end.
module bidir_link_ctrl
   import bidir_link_pkg::*;
#(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned TURN_CYC   = 2,
   parameter int unsigned RX_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   bidir_link_if.slave bus,
   inout  wire        io
);

   localparam int unsigned BW = cnt_w(DATA_W);
   localparam int unsigned TW = cnt_w(TURN_CYC);
   localparam int unsigned WW = cnt_w(RX_TIMEOUT);

   localparam logic [BW-1:0] BitEnd   = BW'(DATA_W);
   localparam logic [BW-1:0] BitLast  = BW'(DATA_W - 1);
   localparam logic [TW-1:0] TurnLast = TW'(TURN_CYC - 1);
   localparam logic [WW-1:0] WaitLast = WW'(RX_TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic [BW-1:0]     bcnt_q, bcnt_d;
   logic [TW-1:0]     tcnt_q, tcnt_d;
   logic [WW-1:0]     wcnt_q, wcnt_d;
   logic              rsp_q, rsp_d;
   logic              drv_q, drv_d;
   logic              oe_q, oe_d;
   logic              ready_q, ready_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              rx_timeout_q, rx_timeout_d;
   logic              pad_in;

   bidir_pad_cell u_pad (
      .oe  (oe_q),
      .out (drv_q),
      .in  (pad_in),
      .io  (io)
   );

   always_comb begin
      state_d      = state_q;
      sh_d         = sh_q;
      bcnt_d       = bcnt_q;
      tcnt_d       = tcnt_q;
      wcnt_d       = wcnt_q;
      rsp_d        = rsp_q;
      drv_d        = drv_q;
      oe_d         = 1'b0;
      rx_data_d    = rx_data_q;
      rx_valid_d   = 1'b0;
      rx_timeout_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.tx_valid && ready_q) begin
               state_d = StTx;
               sh_d    = bus.tx_data;
               rsp_d   = bus.expect_rsp;
               drv_d   = START_LVL;
               oe_d    = 1'b1;
               bcnt_d  = '0;
            end
         end
         StTx: begin
            if (bcnt_q == BitEnd) begin
               state_d = StTurnRx;
               tcnt_d  = '0;
               drv_d   = 1'b0;
            end else begin
               drv_d  = sh_q[0];
               sh_d   = sh_q >> 1;
               bcnt_d = bcnt_q + BW'(1);
               oe_d   = 1'b1;
            end
         end
         StTurnRx: begin
            if (tcnt_q == TurnLast) begin
               tcnt_d  = '0;
               wcnt_d  = '0;
               state_d = rsp_q ? StRxWait : StTurnTx;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         StRxWait: begin
            // if() treats X/Z on the line as "no start bit"
            if (pad_in == START_LVL) begin
               state_d = StRxData;
               bcnt_d  = '0;
            end else if (wcnt_q == WaitLast) begin
               rx_timeout_d = 1'b1;
               state_d      = StTurnTx;
               tcnt_d       = '0;
            end else begin
               wcnt_d = wcnt_q + WW'(1);
            end
         end
         StRxData: begin
            sh_d           = sh_q >> 1;
            sh_d[DATA_W-1] = pad_in;
            if (bcnt_q == BitLast) begin
               rx_data_d  = sh_d;
               rx_valid_d = 1'b1;
               state_d    = StTurnTx;
               tcnt_d     = '0;
            end else begin
               bcnt_d = bcnt_q + BW'(1);
            end
         end
         StTurnTx: begin
            if (tcnt_q == TurnLast) begin
               state_d = StIdle;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
      ready_d = (state_d == StIdle);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         sh_q         <= '0;
         bcnt_q       <= '0;
         tcnt_q       <= '0;
         wcnt_q       <= '0;
         rsp_q        <= 1'b0;
         drv_q        <= 1'b0;
         oe_q         <= 1'b0;
         ready_q      <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         rx_timeout_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sh_q         <= sh_d;
         bcnt_q       <= bcnt_d;
         tcnt_q       <= tcnt_d;
         wcnt_q       <= wcnt_d;
         rsp_q        <= rsp_d;
         drv_q        <= drv_d;
         oe_q         <= oe_d;
         ready_q      <= ready_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         rx_timeout_q <= rx_timeout_d;
      end
   end

   assign bus.tx_ready   = ready_q;
   assign bus.rx_data    = rx_data_q;
   assign bus.rx_valid   = rx_valid_q;
   assign bus.rx_timeout = rx_timeout_q;
   assign bus.busy       = (state_q != StIdle);
   assign bus.io_oe      = oe_q;

endmodule
